window_conv_filter: RTL and testbench
=====================================

// Module: window_conv_filter
//
// PURPOSE
// - Consumer of the windowing stage: turns each WIN_SIZE x WIN_SIZE pixel window into one filtered pixel.
// - Convolves each window with a constant signed kernel, then rounds, right-shifts and clamps.
// - Emits a pixel stream in the same lane format as the pipeline input, with sideband flags delay-matched.
// - Feeds the next streaming stage or the video output.
//
// PARAMETERS
// - PX_WIDTH    12                       bits per pixel
// - PX_PER_CLK  4                        pixel lanes per clock
// - WIN_SIZE    3                        window edge length; odd, >=3
// - COEF_WIDTH  8                        signed coefficient width
// - COEF        '{1,2,1,2,4,2,1,2,1}     kernel, index row*WIN_SIZE+col; default Gaussian
// - SHIFT       4                        right shift after summation; 0 = none
//
// PORTS
// - clk_i           in   1                                   pixel clock
// - rst_i           in   1                                   async reset, active-high
// - win_data_i      in   PX_PER_CLK*WIN_SIZE^2*PX_WIDTH      [lane][row][col] windows
// - win_data_val_i  in   PX_PER_CLK                          per-lane window valid
// - line_start_i    in   1                                   first word of line
// - line_end_i      in   1                                   last word of line
// - frame_start_i   in   1                                   first word of frame
// - frame_end_i     in   1                                   last word of frame
// - bypass_i        in   1                                   1 = pass centre pixel unfiltered
// - px_data_o       out  PX_PER_CLK*PX_WIDTH                 filtered pixels
// - px_data_val_o   out  PX_PER_CLK                          per-lane valid
// - line_start_o    out  1                                   delayed line_start_i
// - line_end_o      out  1                                   delayed line_end_i
// - frame_start_o   out  1                                   delayed frame_start_i
// - frame_end_o     out  1                                   delayed frame_end_i
//
// BEHAVIOUR
// - Reset and flags:
//   - rst_i is asynchronous: every pipeline register, every output and bypass_q clear to 0.
//   - Reset mid-frame flushes the pipeline; nothing is emitted until new input is accepted.
// - Timing:
//   - Latency is exactly 3 clk_i cycles, input to output, for data, valid and all four flags.
//   - Bypass does not change the latency.
//   - No backpressure. A new word is accepted every cycle.
// - Data path:
//   - Lanes are independent.
//   - A lane whose val is 0 outputs px_data 0 and val 0.
//   - The four flags pass through a 3-deep shift register, unaltered.
// - Pipeline stages:
//   - S1 registers the products p[r][c] = $signed({1'b0,win[r][c]}) * COEF[r*WIN_SIZE+c].
//   - S2 registers the per-row sums.
//   - S3 adds the row sums to give s and registers the clamped result.
// - Arithmetic:
//   - Products and sums are full precision, with no overflow.
//   - Sum width is PX_WIDTH+COEF_WIDTH+1+$clog2(WIN_SIZE^2), signed.
//   - SHIFT>0: t = (s + (1<<(SHIFT-1))) >>> SHIFT, i.e. round half up.
//   - SHIFT=0: t = s.
//   - Output = 0 if t<0; 2^PX_WIDTH-1 if t>2^PX_WIDTH-1; otherwise t[PX_WIDTH-1:0].
// - Bypass:
//   - bypass_q is loaded from bypass_i only in a cycle where frame_start_i=1 and any win_data_val_i bit is 1.
//   - It applies from that word onward and stays constant for the whole frame; changes to bypass_i mid-frame are ignored.
//   - When bypass_q=1, output = win[WIN_SIZE/2][WIN_SIZE/2], delayed 3 cycles.
//   - The bypass select is pipelined alongside the data, so the filtered/bypassed change happens exactly at the output frame_start.
// - Simultaneous frame_start_i and frame_end_i in one word (1-line frame): both are propagated in the same output cycle.
//
// STRUCTURE
// - Package video_filter_pkg:
//   - coef_arr_t, an int array type for COEF.
//   - Functions sum_width() and clamp_px(), plus a PX_MAX constant.
// - Sub-module window_conv_lane:
//   - One lane's S1..S3 data path plus the bypass mux.
//   - Instantiated PX_PER_CLK times by a generate loop.
// - Top level holds the flag/valid/bypass_q delay line.
//
// TESTING
// - Flat window: all 9 pixels = 100, default COEF and SHIFT, val=4'hF -> after 3 cycles every lane = 100, val=4'hF.
// - Impulse: centre = 4095, others 0 -> output 1024 ((4095*4+8)>>4).
//   - Moving the impulse to the [0][0] corner -> output 256.
// - Clamp: COEF = '{-1,-1,-1,-1,8,-1,-1,-1,-1}, SHIFT=0.
//   - Centre 0, others 4095 -> output 0.
//   - Centre 4095, others 0 -> output 4095.
// - Bypass:
//   - Setting bypass_i=1 mid-frame -> output still filtered.
//   - At the next frame_start_i -> output = centre pixel, switching exactly at frame_start_o.
// - Partial word: line_end_i with val=4'b0011 -> 3 cycles later line_end_o=1, val_o=4'b0011, lanes 2-3 = 0.
// - Reset: assert rst_i asynchronously mid-frame -> all outputs 0 immediately.
//   - After release, output is silent until 3 cycles after the next valid input.

Source files
------------

// File: rtl/video_filter_pkg.sv
// Shared types and helpers for the window convolution filter.
//   coef_arr_t  : kernel array type for the default 3x3 window
//   COEF_GAUSS  : default 3x3 Gaussian kernel, index row*WIN_SIZE+col
//   PX_MAX      : full-scale pixel value at the default 12-bit width
//   sum_width() : accumulator width that cannot overflow
//   clamp_px()  : saturate a signed result into [0, 2^px_w-1]
package video_filter_pkg;

   localparam int WIN_DEF      = 3;
   localparam int PX_WIDTH_DEF = 12;
   localparam int PX_MAX       = (1 << PX_WIDTH_DEF) - 1;

   typedef int coef_arr_t [WIN_DEF*WIN_DEF];

   localparam coef_arr_t COEF_GAUSS = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

   function automatic int sum_width(input int px_w, input int coef_w, input int win);
      return px_w + coef_w + 1 + $clog2(win * win);
   endfunction

   function automatic longint clamp_px(input longint t, input int px_w);
      longint hi;
      hi = (longint'(1) << px_w) - 1;
      if (t < 0) return 0;
      if (t > hi) return hi;
      return t;
   endfunction

endpackage

// File: rtl/window_conv_lane.sv
// One pixel lane of the window convolution filter.
//   S1: per-tap products, S2: per-row sums, S3: total, round, shift, clamp.
//   clk_i, rst_i : pixel clock, async active-high reset
//   win_i        : WIN_SIZE x WIN_SIZE window, tap (r,c) at bits [(r*WIN_SIZE+c)*PX_WIDTH +: PX_WIDTH]
//   val_s2_i     : lane valid, already delayed to line up with the S2 row sums
//   sel_s2_i     : bypass select, already delayed to line up with the S2 row sums
//   px_o         : registered output pixel (0 when the lane is not valid)
module window_conv_lane
   import video_filter_pkg::*;
#(
   parameter int PX_WIDTH   = 12,
   parameter int COEF_WIDTH = 8,
   parameter int WIN_SIZE   = 3,
   parameter int COEF [WIN_SIZE*WIN_SIZE] = COEF_GAUSS,
   parameter int SHIFT      = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [WIN_SIZE*WIN_SIZE*PX_WIDTH-1:0] win_i,
   input  logic                                val_s2_i,
   input  logic                                sel_s2_i,
   output logic [PX_WIDTH-1:0]                 px_o
);

   localparam int TAPS  = WIN_SIZE * WIN_SIZE;
   localparam int SUM_W = sum_width(PX_WIDTH, COEF_WIDTH, WIN_SIZE);
   localparam int CTR   = (WIN_SIZE / 2) * WIN_SIZE + WIN_SIZE / 2;
   localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   // Half-LSB of the shifted result; adding it before the arithmetic shift rounds half up.
   localparam logic signed [SUM_W-1:0] RND = (SHIFT > 0) ? (SUM_W'(1) << HALF_SH) : '0;

   logic signed [SUM_W-1:0] prod_d [TAPS];
   logic signed [SUM_W-1:0] prod_q [TAPS];
   logic signed [SUM_W-1:0] row_d  [WIN_SIZE];
   logic signed [SUM_W-1:0] row_q  [WIN_SIZE];
   logic [PX_WIDTH-1:0]     ctr1_d, ctr1_q, ctr2_d, ctr2_q;
   logic [PX_WIDTH-1:0]     px_d, px_q;
   logic signed [SUM_W-1:0] sum_s, rnd_t;

   always_comb begin
      for (int i = 0; i < TAPS; i++) begin
         // Pixels are unsigned; widen with a zero MSB before the signed multiply.
         prod_d[i] = SUM_W'($signed({1'b0, win_i[i*PX_WIDTH +: PX_WIDTH]})) * SUM_W'(COEF[i]);
      end
      for (int r = 0; r < WIN_SIZE; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < WIN_SIZE; c++) begin
            row_d[r] = row_d[r] + prod_q[r*WIN_SIZE + c];
         end
      end
      sum_s = '0;
      for (int r = 0; r < WIN_SIZE; r++) begin
         sum_s = sum_s + row_q[r];
      end
      rnd_t  = (sum_s + RND) >>> SHIFT;
      ctr1_d = win_i[CTR*PX_WIDTH +: PX_WIDTH];
      ctr2_d = ctr1_q;
      px_d   = '0;
      if (val_s2_i) begin
         px_d = sel_s2_i ? ctr2_q : PX_WIDTH'(clamp_px(longint'(rnd_t), PX_WIDTH));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
         for (int r = 0; r < WIN_SIZE; r++) row_q[r] <= '0;
         ctr1_q <= '0;
         ctr2_q <= '0;
         px_q   <= '0;
      end else begin
         for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
         for (int r = 0; r < WIN_SIZE; r++) row_q[r] <= row_d[r];
         ctr1_q <= ctr1_d;
         ctr2_q <= ctr2_d;
         px_q   <= px_d;
      end
   end

   assign px_o = px_q;

endmodule

// File: rtl/window_conv_filter.sv
// Window convolution filter: one filtered pixel per incoming window, per lane.
// Three-cycle latency for data, valid and flags; no backpressure.
//   clk_i, rst_i       : pixel clock, async active-high reset
//   win_data_i         : PX_PER_CLK windows, lane l at [l*WIN_SIZE^2*PX_WIDTH +: WIN_SIZE^2*PX_WIDTH]
//   win_data_val_i     : per-lane window valid
//   line/frame flags   : start/end markers, delayed 3 cycles unaltered
//   bypass_i           : sampled at frame start; 1 = emit centre pixel unfiltered
//   px_data_o          : filtered pixels, same lane layout as the input stream
//   px_data_val_o      : per-lane valid
module window_conv_filter
   import video_filter_pkg::*;
#(
   parameter int PX_WIDTH   = 12,
   parameter int PX_PER_CLK = 4,
   parameter int WIN_SIZE   = 3,
   parameter int COEF_WIDTH = 8,
   parameter int COEF [WIN_SIZE*WIN_SIZE] = COEF_GAUSS,
   parameter int SHIFT      = 4
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic [PX_PER_CLK*WIN_SIZE*WIN_SIZE*PX_WIDTH-1:0] win_data_i,
   input  logic [PX_PER_CLK-1:0]                       win_data_val_i,
   input  logic                                        line_start_i,
   input  logic                                        line_end_i,
   input  logic                                        frame_start_i,
   input  logic                                        frame_end_i,
   input  logic                                        bypass_i,
   output logic [PX_PER_CLK*PX_WIDTH-1:0]              px_data_o,
   output logic [PX_PER_CLK-1:0]                       px_data_val_o,
   output logic                                        line_start_o,
   output logic                                        line_end_o,
   output logic                                        frame_start_o,
   output logic                                        frame_end_o
);

   localparam int WIN_BITS = WIN_SIZE * WIN_SIZE * PX_WIDTH;

   logic [PX_PER_CLK-1:0] val_d;
   logic [PX_PER_CLK-1:0] val_q [3];
   logic [3:0]            flag_d;
   logic [3:0]            flag_q [3];
   logic                  bypass_d, bypass_q;
   logic                  sel_d;
   logic [1:0]            sel_q;

   always_comb begin
      val_d    = win_data_val_i;
      flag_d   = {line_start_i, line_end_i, frame_start_i, frame_end_i};
      bypass_d = bypass_q;
      sel_d    = bypass_q;
      // The frame-start word itself already uses the new mode.
      if (frame_start_i && |win_data_val_i) begin
         bypass_d = bypass_i;
         sel_d    = bypass_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 3; i++) begin
            val_q[i]  <= '0;
            flag_q[i] <= '0;
         end
         sel_q    <= '0;
         bypass_q <= 1'b0;
      end else begin
         val_q[0]  <= val_d;
         val_q[1]  <= val_q[0];
         val_q[2]  <= val_q[1];
         flag_q[0] <= flag_d;
         flag_q[1] <= flag_q[0];
         flag_q[2] <= flag_q[1];
         sel_q     <= {sel_q[0], sel_d};
         bypass_q  <= bypass_d;
      end
   end

   for (genvar l = 0; l < PX_PER_CLK; l++) begin : g_lane
      window_conv_lane #(
         .PX_WIDTH   (PX_WIDTH),
         .COEF_WIDTH (COEF_WIDTH),
         .WIN_SIZE   (WIN_SIZE),
         .COEF       (COEF),
         .SHIFT      (SHIFT)
      ) u_lane (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .win_i    (win_data_i[l*WIN_BITS +: WIN_BITS]),
         .val_s2_i (val_q[1][l]),
         .sel_s2_i (sel_q[1]),
         .px_o     (px_data_o[l*PX_WIDTH +: PX_WIDTH])
      );
   end

   assign px_data_val_o = val_q[2];
   assign line_start_o  = flag_q[2][3];
   assign line_end_o    = flag_q[2][2];
   assign frame_start_o = flag_q[2][1];
   assign frame_end_o   = flag_q[2][0];

endmodule

// File: tb/tb_window_conv_filter.sv
module tb_window_conv_filter;
   import video_filter_pkg::*;

   localparam int LAP [9] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [431:0]  win_data = '0;
   logic [3:0]    win_val = '0;
   logic          ls_i = 1'b0, le_i = 1'b0, fs_i = 1'b0, fe_i = 1'b0;
   logic          byp = 1'b0;

   logic [47:0]   px_g, px_l;
   logic [3:0]    val_g, val_l;
   logic          ls_g, le_g, fs_g, fe_g;
   logic          ls_l, le_l, fs_l, fe_l;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   window_conv_filter dut (
      .clk_i(clk), .rst_i(rst), .win_data_i(win_data), .win_data_val_i(win_val),
      .line_start_i(ls_i), .line_end_i(le_i), .frame_start_i(fs_i), .frame_end_i(fe_i),
      .bypass_i(byp), .px_data_o(px_g), .px_data_val_o(val_g),
      .line_start_o(ls_g), .line_end_o(le_g), .frame_start_o(fs_g), .frame_end_o(fe_g)
   );

   window_conv_filter #(.COEF(LAP), .SHIFT(0)) dut_lap (
      .clk_i(clk), .rst_i(rst), .win_data_i(win_data), .win_data_val_i(win_val),
      .line_start_i(ls_i), .line_end_i(le_i), .frame_start_i(fs_i), .frame_end_i(fe_i),
      .bypass_i(byp), .px_data_o(px_l), .px_data_val_o(val_l),
      .line_start_o(ls_l), .line_end_o(le_l), .frame_start_o(fs_l), .frame_end_o(fe_l)
   );

   typedef logic [8:0][11:0] win_t;

   typedef struct {
      string      name;
      win_t       pix;
      logic [3:0] val;
      logic [3:0] flags;   // {line_start, line_end, frame_start, frame_end}
      logic [11:0] exp_g;
      logic [11:0] exp_l;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] exp_bus(input logic [11:0] v, input logic [3:0] val);
      logic [47:0] b;
      for (int l = 0; l < 4; l++) b[l*12 +: 12] = val[l] ? v : 12'd0;
      return b;
   endfunction

   function automatic win_t mk_win(input logic [11:0] ctr, input logic [11:0] others);
      win_t w;
      for (int i = 0; i < 9; i++) w[i] = (i == 4) ? ctr : others;
      return w;
   endfunction

   task automatic drive(input win_t w, input logic [3:0] val, input logic [3:0] flags, input logic b);
      win_data = {4{w}};
      win_val  = val;
      {ls_i, le_i, fs_i, fe_i} = flags;
      byp      = b;
   endtask

   task automatic drive_idle();
      drive('0, 4'h0, 4'h0, 1'b0);
   endtask

   vec_t vecs [10];
   win_t corner, w_byp;
   win_t bs_win [6];
   logic [3:0] bs_flag [6];
   logic       bs_byp [6];
   logic [3:0] bs_val [6];
   logic [11:0] bs_exp [6];

   initial begin
      corner = '0;
      corner[0] = 12'd4095;
      //           name          window                        val    flags  gauss   lap
      vecs[0] = '{"flat100",    mk_win(12'd100, 12'd100),    4'hF, 4'h8, 12'd100,  12'd0};
      vecs[1] = '{"impulse_c",  mk_win(12'd4095, 12'd0),     4'hF, 4'h0, 12'd1024, 12'd4095};
      vecs[2] = '{"impulse_00", corner,                      4'hF, 4'h0, 12'd256,  12'd0};
      vecs[3] = '{"hole_c",     mk_win(12'd0, 12'd4095),     4'hF, 4'h0, 12'd3071, 12'd0};
      vecs[4] = '{"full_scale", mk_win(12'd4095, 12'd4095),  4'hF, 4'h0, 12'd4095, 12'd0};
      vecs[5] = '{"round_up",   mk_win(12'd2, 12'd0),        4'hF, 4'h0, 12'd1,    12'd16};
      vecs[6] = '{"round_dn",   mk_win(12'd1, 12'd0),        4'hF, 4'h0, 12'd0,    12'd8};
      vecs[7] = '{"partial",    mk_win(12'd100, 12'd100),    4'b0011, 4'h4, 12'd100, 12'd0};
      vecs[8] = '{"no_val",     mk_win(12'd500, 12'd7),      4'h0, 4'h0, 12'd0,    12'd0};
      vecs[9] = '{"one_line",   mk_win(12'd3, 12'd0),        4'b0101, 4'h3, 12'd1, 12'd24};

      // Reset state
      drive_idle();
      rst = 1'b1;
      #12;
      chk("reset_px", {px_g, px_l}, '0);
      chk("reset_val_flags", {val_g, val_l, ls_g, le_g, fs_g, fe_g}, '0);
      @(negedge clk);
      rst = 1'b0;

      // Table: one word, then idle; output must be absent after 2 edges and present after 3.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(vecs[i].pix, vecs[i].val, vecs[i].flags, 1'b0);
         @(negedge clk);
         drive_idle();
         @(negedge clk);
         chk({vecs[i].name, "_early"}, {val_g, ls_g, le_g, fs_g, fe_g}, '0);
         @(negedge clk);
         chk({vecs[i].name, "_px"},    px_g, exp_bus(vecs[i].exp_g, vecs[i].val));
         chk({vecs[i].name, "_val"},   val_g, vecs[i].val);
         chk({vecs[i].name, "_flags"}, {ls_g, le_g, fs_g, fe_g}, vecs[i].flags);
         chk({vecs[i].name, "_lap"},   {px_l, val_l, ls_l, le_l, fs_l, fe_l},
             {exp_bus(vecs[i].exp_l, vecs[i].val), vecs[i].val, vecs[i].flags});
      end

      // Bypass: mid-frame request ignored, takes effect at the next frame start.
      // Centre 2000, others 0: filtered = (8000+8)>>4 = 500.
      w_byp = mk_win(12'd2000, 12'd0);
      for (int k = 0; k < 6; k++) begin
         bs_win[k] = w_byp; bs_val[k] = 4'hF; bs_flag[k] = 4'h0;
      end
      bs_flag[0] = 4'h2; bs_byp[0] = 1'b0; bs_exp[0] = 12'd500;
      bs_byp[1] = 1'b1;  bs_exp[1] = 12'd500;
      bs_flag[2] = 4'h1; bs_byp[2] = 1'b1; bs_exp[2] = 12'd500;
      bs_flag[3] = 4'h2; bs_byp[3] = 1'b1; bs_exp[3] = 12'd2000;
      bs_byp[4] = 1'b0;  bs_exp[4] = 12'd2000;
      bs_win[5] = '0; bs_val[5] = 4'h0; bs_byp[5] = 1'b0; bs_exp[5] = 12'd0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k >= 3) begin
            chk($sformatf("bypass_px_%0d", k - 3), px_g, exp_bus(bs_exp[k-3], bs_val[k-3]));
            chk($sformatf("bypass_fs_%0d", k - 3), {fs_g, fe_g}, bs_flag[k-3][1:0]);
         end
         if (k < 6) drive(bs_win[k], bs_val[k], bs_flag[k], bs_byp[k]);
         else drive_idle();
      end

      // Reset mid-frame while bypass is latched and the pipeline is full.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(w_byp, 4'hF, 4'h8, 1'b0);
      end
      @(negedge clk);
      chk("pre_reset_bypass_px", px_g, exp_bus(12'd2000, 4'hF));
      #2 rst = 1'b1;
      #1;
      chk("async_reset_px", {px_g, px_l}, '0);
      chk("async_reset_val_flags", {val_g, val_l, ls_g, le_g, fs_g, fe_g}, '0);
      drive_idle();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post_reset_silent_%0d", k), {px_g, val_g, ls_g, le_g, fs_g, fe_g}, '0);
      end
      drive(w_byp, 4'hF, 4'h0, 1'b0);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      chk("post_reset_early", val_g, 4'h0);
      @(negedge clk);
      chk("post_reset_filtered", px_g, exp_bus(12'd500, 4'hF));
      chk("post_reset_val", val_g, 4'hF);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
